// File: rtl/ls193_seq_pkg.sv
// Shared types and defaults for the LS193 counter-chain sequencer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: op_t command encoding, state_t sequencer FSM states,
//           phase_t strobe timer phases, default strobe timing, cnt_bits().
package ls193_seq_pkg;

  // Command encoding as seen on cmd_op.
  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ACT,
    S_GAP
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ACT,
    PH_GAP
  } phase_t;

  localparam int DEF_PULSE_W = 2;
  localparam int DEF_GAP_W   = 2;

  // Bits needed to count 0..max(a,b)-1; never less than one bit.
  function automatic int cnt_bits(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ls193_seq_if.sv
// Command handshake plus LS193 chain pins for the sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready; requester holds payload while cmd_ready=0.
// slave  = sequencer: takes cmd_valid/cmd_op/cmd_arg/q, drives the rest.
// master = controller/chain side: mirror image.
interface ls193_seq_if
  import ls193_seq_pkg::*;
#(
  parameter int WIDTH = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             clr;
  logic             load_n;
  logic             up_n;
  logic             down_n;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] shadow;
  logic             done;
  logic             wrap;
  logic             mismatch;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, q,
    input  cmd_ready, clr, load_n, up_n, down_n, data, shadow, done, wrap, mismatch
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, q,
    output cmd_ready, clr, load_n, up_n, down_n, data, shadow, done, wrap, mismatch
  );
endinterface

// File: rtl/ls193_strobe_timer.sv
// Strobe timer: PULSE_W-cycle active phase followed by a GAP_W-cycle gap.
// Latency: active from the cycle after start; gap_end in the last gap cycle.
// Backpressure: none; start restarts the sequence (also legal on gap_end).
// Ports: start / skip_act (begin directly in the gap phase) in;
//        active, busy, act_end, gap_end out (act_end/gap_end flag last cycle of a phase).
module ls193_strobe_timer
  import ls193_seq_pkg::*;
#(
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic skip_act,
  output logic active,
  output logic busy,
  output logic act_end,
  output logic gap_end
);
  localparam int CW = cnt_bits(PULSE_W, GAP_W);
  localparam logic [CW-1:0] ACT_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_W - 1);

  phase_t          phase_q, phase_d;
  logic   [CW-1:0] cnt_q, cnt_d;

  assign active  = (phase_q == PH_ACT);
  assign busy    = (phase_q != PH_IDLE);
  assign act_end = (phase_q == PH_ACT) && (cnt_q == ACT_LAST);
  assign gap_end = (phase_q == PH_GAP) && (cnt_q == GAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (start) begin
      phase_d = skip_act ? PH_GAP : PH_ACT;
      cnt_d   = '0;
    end else if (act_end) begin
      phase_d = PH_GAP;
      cnt_d   = '0;
    end else if (gap_end) begin
      phase_d = PH_IDLE;
      cnt_d   = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/ls193_seq.sv
// Command sequencer driving a cascade of LS193 up/down counters, with shadow count.
// Latency: CLR/LOAD done after PULSE_W+GAP_W edges; UP/DOWN N after N*(PULSE_W+GAP_W), N=0 after GAP_W.
// Backpressure: cmd_ready high only in IDLE; one command in flight at a time.
// Ports: clk, rst (sync, active-high); bus (ls193_seq_if.slave): command handshake,
//        chain strobes clr/load_n/up_n/down_n, data, q readback, shadow, done, wrap, mismatch.
// Build option: LS193_SEQ_CHECK_EN adds the sticky q-vs-shadow compare; otherwise mismatch is 0.
module ls193_seq
  import ls193_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input logic        clk,
  input logic        rst,
  ls193_seq_if.slave bus
);
  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] remain_q, remain_d;   // pulses still to issue, incl. the active one
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic clr_q, clr_d, load_n_q, load_n_d, up_n_q, up_n_d, down_n_q, down_n_d;
  logic done_q, done_d, wrap_q, wrap_d, ready_q, ready_d;
  logic tmr_start, tmr_skip, tmr_busy, tmr_act_end, tmr_gap_end, unused_tmr_active;
  logic check;      // compare point: end of INIT and every DONE edge
  logic clr_cmd;    // accepted CLR command, also clears the sticky error

  ls193_strobe_timer #(.PULSE_W(PULSE_W), .GAP_W(GAP_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (tmr_start),
    .skip_act (tmr_skip),
    .active   (unused_tmr_active),
    .busy     (tmr_busy),
    .act_end  (tmr_act_end),
    .gap_end  (tmr_gap_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      op_q     <= OP_CLR;
      remain_q <= '0;
      data_q   <= '0;
      shadow_q <= '0;
      clr_q    <= 1'b0;
      load_n_q <= 1'b1;
      up_n_q   <= 1'b1;
      down_n_q <= 1'b1;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
      clr_q    <= clr_d;
      load_n_q <= load_n_d;
      up_n_q   <= up_n_d;
      down_n_q <= down_n_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    remain_d  = remain_q;
    data_d    = data_q;
    shadow_d  = shadow_q;
    clr_d     = clr_q;
    load_n_d  = load_n_q;
    up_n_d    = up_n_q;
    down_n_d  = down_n_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    tmr_start = 1'b0;
    tmr_skip  = 1'b0;
    check     = 1'b0;
    clr_cmd   = 1'b0;
    case (state_q)
      S_INIT: begin
        // Timer idle only on the first cycle out of reset: fire the clear pulse once.
        if (!tmr_busy) begin
          tmr_start = 1'b1;
          clr_d     = 1'b1;
        end else if (tmr_act_end) begin
          clr_d = 1'b0;
        end else if (tmr_gap_end) begin
          state_d = S_IDLE;
          check   = 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          op_d      = bus.cmd_op;
          remain_d  = bus.cmd_arg;
          tmr_start = 1'b1;
          state_d   = S_ACT;
          case (bus.cmd_op)
            OP_CLR: begin
              clr_d   = 1'b1;
              clr_cmd = 1'b1;
            end
            OP_LOAD: begin
              data_d   = bus.cmd_arg;
              load_n_d = 1'b0;
            end
            default: begin
              // UP/DOWN with N=0 only spends the settle gap.
              if (bus.cmd_arg == '0) begin
                tmr_skip = 1'b1;
                state_d  = S_GAP;
              end else if (bus.cmd_op == OP_UP) begin
                up_n_d = 1'b0;
              end else begin
                down_n_d = 1'b0;
              end
            end
          endcase
        end
      end
      S_ACT: begin
        // Strobe release edge: the chain acts here, so the shadow follows here too.
        if (tmr_act_end) begin
          state_d  = S_GAP;
          clr_d    = 1'b0;
          load_n_d = 1'b1;
          up_n_d   = 1'b1;
          down_n_d = 1'b1;
          case (op_q)
            OP_CLR:  shadow_d = '0;
            OP_LOAD: shadow_d = data_q;
            OP_UP: begin
              shadow_d = shadow_q + WIDTH'(1);
              wrap_d   = &shadow_q;
              remain_d = remain_q - WIDTH'(1);
            end
            default: begin
              shadow_d = shadow_q - WIDTH'(1);
              wrap_d   = (shadow_q == '0);
              remain_d = remain_q - WIDTH'(1);
            end
          endcase
        end
      end
      S_GAP: begin
        if (tmr_gap_end) begin
          if ((op_q == OP_UP || op_q == OP_DOWN) && remain_q != '0) begin
            tmr_start = 1'b1;
            state_d   = S_ACT;
            if (op_q == OP_UP) up_n_d = 1'b0;
            else               down_n_d = 1'b0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            check   = 1'b1;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Registered so cmd_ready rises together with DONE.
  assign ready_d = (state_d == S_IDLE);

  assign bus.cmd_ready = ready_q;
  assign bus.clr       = clr_q;
  assign bus.load_n    = load_n_q;
  assign bus.up_n      = up_n_q;
  assign bus.down_n    = down_n_q;
  assign bus.data      = data_q;
  assign bus.shadow    = shadow_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;

`ifdef LS193_SEQ_CHECK_EN
  logic mismatch_q;
  always_ff @(posedge clk) begin
    if (rst)                              mismatch_q <= 1'b0;
    else if (clr_cmd)                     mismatch_q <= 1'b0;
    else if (check && bus.q != shadow_q)  mismatch_q <= 1'b1;
  end
  assign bus.mismatch = mismatch_q;
`else
  logic unused_chk;
  assign unused_chk   = ^{check, clr_cmd, bus.q};
  assign bus.mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_ls193_seq.sv
// Bench for ls193_seq: two cascaded 4-bit LS193 models on the strobes, q fed back,
// randomized commands checked against an arithmetic reference of the counter value.
module tb_ls193_seq;
  import ls193_seq_pkg::*;

  localparam int W      = 8;
  localparam int PW     = 2;
  localparam int GW     = 2;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ls193_seq_if #(.WIDTH(W)) bus ();

  ls193_seq #(.WIDTH(W), .PULSE_W(PW), .GAP_W(GW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Counter chain: lower nibble carries/borrows into the upper one.
  logic [3:0] ch_lo = 4'hA;
  logic [3:0] ch_hi = 4'h5;
  assign bus.q = {ch_hi, ch_lo};

  int up_rises = 0, down_rises = 0, wraps = 0, wrap_at_ups = 0;
  int done_cnt = 0, viol = 0, up_low = 0, drops_req = 0, drops_done = 0;
  logic prev_up = 1'b1, prev_down = 1'b1;
  logic [W-1:0] model_val;

  // Strobes change on posedge only; look at them mid-cycle.
  always @(negedge clk) begin
    if (bus.clr) begin
      ch_lo = 4'h0;
      ch_hi = 4'h0;
    end else if (!bus.load_n) begin
      {ch_hi, ch_lo} = bus.data;
    end else if (!prev_up && bus.up_n) begin
      if (drops_done < drops_req) begin
        drops_done++;
      end else begin
        if (ch_lo == 4'hF) ch_hi = ch_hi + 4'h1;
        ch_lo = ch_lo + 4'h1;
      end
    end else if (!prev_down && bus.down_n) begin
      if (ch_lo == 4'h0) ch_hi = ch_hi - 4'h1;
      ch_lo = ch_lo - 4'h1;
    end
    if (!prev_up && bus.up_n)     up_rises++;
    if (!prev_down && bus.down_n) down_rises++;
    if (bus.wrap) begin
      wraps++;
      wrap_at_ups = up_rises;
    end
    if (bus.done)  done_cnt++;
    if (!bus.up_n) up_low++;
    if (int'(bus.clr) + int'(!bus.load_n) + int'(!bus.up_n) + int'(!bus.down_n) > 1) viol++;
    prev_up   = bus.up_n;
    prev_down = bus.down_n;
  end

  // Offer a command, wait for acceptance and completion; lat = edges from accept to DONE.
  task automatic run_cmd(input op_t op, input logic [W-1:0] arg, output int lat, output bit to);
    int n;
    n = 0;
    to = 1'b0;
    bus.cmd_op = op;
    bus.cmd_arg = arg;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      to = 1'b1;
      lat = -1;
      return;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.done && lat < BUDGET) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.done) to = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_clr [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_rdy [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.clr, bus.load_n, bus.up_n, bus.down_n, bus.done, bus.wrap, bus.mismatch, bus.cmd_ready} !== 8'b0111_0000) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b want 01110000",
               {bus.clr, bus.load_n, bus.up_n, bus.down_n, bus.done, bus.wrap, bus.mismatch, bus.cmd_ready});
    end
    tests_run++;
    if ({bus.data, bus.shadow} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_data_shadow: got %h want 0000", {bus.data, bus.shadow});
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus.clr !== exp_clr[k] || bus.cmd_ready !== exp_rdy[k]) begin
        tests_failed++;
        $display("FAIL init_cycle%0d: clr/ready got %b%b want %b%b", k, bus.clr, bus.cmd_ready, exp_clr[k], exp_rdy[k]);
      end
    end
    tests_run++;
    if (bus.q !== 8'h00 || bus.mismatch !== 1'b0) begin
      tests_failed++;
      $display("FAIL init_q: q=%h mismatch=%b want 00/0", bus.q, bus.mismatch);
    end
    model_val = '0;
  endtask

  task automatic test_load_up();
    int lat, u0, w0;
    bit to;
    run_cmd(OP_LOAD, 8'hE7, lat, to);
    tests_run++;
    if (to || lat != PW + GW || bus.shadow !== 8'hE7 || bus.q !== 8'hE7 || bus.data !== 8'hE7) begin
      tests_failed++;
      $display("FAIL load_e7: to=%0d lat=%0d shadow=%h q=%h data=%h want lat %0d all e7",
               to, lat, bus.shadow, bus.q, bus.data, PW + GW);
    end
    u0 = up_rises;
    w0 = wraps;
    run_cmd(OP_UP, 8'd25, lat, to);
    tests_run++;
    if (to || lat != 100) begin
      tests_failed++;
      $display("FAIL up25_latency: got %0d (timeout %0d) want 100", lat, to);
    end
    tests_run++;
    if (bus.q !== 8'h00 || bus.shadow !== 8'h00 || bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL up25_value: q=%h shadow=%h ready=%b want 00 00 1", bus.q, bus.shadow, bus.cmd_ready);
    end
    tests_run++;
    if (wraps - w0 != 1 || wrap_at_ups - u0 != 25 || up_rises - u0 != 25) begin
      tests_failed++;
      $display("FAIL up25_wrap: wraps=%0d at_pulse=%0d pulses=%0d want 1 25 25",
               wraps - w0, wrap_at_ups - u0, up_rises - u0);
    end
    model_val = '0;
  endtask

  task automatic test_down_wrap();
    int lat, w0, ul0, d0;
    bit to;
    w0 = wraps; ul0 = up_low; d0 = down_rises;
    run_cmd(OP_DOWN, 8'd1, lat, to);
    tests_run++;
    if (to || lat != PW + GW || bus.q !== 8'hFF || bus.shadow !== 8'hFF) begin
      tests_failed++;
      $display("FAIL down1: to=%0d lat=%0d q=%h shadow=%h want 4 ff ff", to, lat, bus.q, bus.shadow);
    end
    tests_run++;
    if (wraps - w0 != 1 || up_low - ul0 != 0 || down_rises - d0 != 1) begin
      tests_failed++;
      $display("FAIL down1_strobes: wraps=%0d up_low=%0d downs=%0d want 1 0 1",
               wraps - w0, up_low - ul0, down_rises - d0);
    end
    model_val = 8'hFF;
  endtask

  task automatic test_up_zero();
    int lat, u0, d0, ul0;
    bit to;
    u0 = up_rises; d0 = down_rises; ul0 = up_low;
    run_cmd(OP_UP, 8'd0, lat, to);
    tests_run++;
    if (to || lat != GW) begin
      tests_failed++;
      $display("FAIL up0_latency: got %0d (timeout %0d) want %0d", lat, to, GW);
    end
    tests_run++;
    if (up_rises != u0 || down_rises != d0 || up_low != ul0 || bus.shadow !== model_val) begin
      tests_failed++;
      $display("FAIL up0_nostrobe: ups=%0d downs=%0d lows=%0d shadow=%h want 0 0 0 %h",
               up_rises - u0, down_rises - d0, up_low - ul0, bus.shadow, model_val);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit to;
    run_cmd(OP_LOAD, 8'h10, n, to);
    // Second command offered while the first is still running.
    bus.cmd_op = OP_LOAD; bus.cmd_arg = 8'h10; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < BUDGET) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.cmd_op = OP_UP; bus.cmd_arg = 8'd2;
    n = 0;
    while (!bus.done && n < BUDGET) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n != PW + GW || bus.cmd_ready !== 1'b1 || bus.shadow !== 8'h10) begin
      tests_failed++;
      $display("FAIL b2b_first: lat=%0d ready=%b shadow=%h want %0d 1 10", n, bus.cmd_ready, bus.shadow, PW + GW);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    tests_run++;
    if (bus.up_n !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: up_n=%b ready=%b want 0 0", bus.up_n, bus.cmd_ready);
    end
    n = 1;
    while (!bus.done && n < BUDGET) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n != 1 + 2 * (PW + GW) || bus.shadow !== 8'h12 || bus.q !== 8'h12) begin
      tests_failed++;
      $display("FAIL b2b_second: edges=%0d shadow=%h q=%h want %0d 12 12", n, bus.shadow, bus.q, 1 + 2 * (PW + GW));
    end
    model_val = 8'h12;
  endtask

  task automatic test_random();
    int lat, n, exp_lat, exp_wr, u0, d0, w0;
    bit to;
    op_t op;
    logic [W-1:0] arg;
    for (int i = 0; i < 30; i++) begin
      op = op_t'($urandom_range(0, 3));
      arg = (op == OP_UP || op == OP_DOWN) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 255));
      n = int'(arg);
      u0 = up_rises; d0 = down_rises; w0 = wraps;
      case (op)
        OP_CLR:  begin exp_lat = PW + GW; exp_wr = 0; model_val = '0; end
        OP_LOAD: begin exp_lat = PW + GW; exp_wr = 0; model_val = arg; end
        OP_UP: begin
          exp_lat = (n == 0) ? GW : n * (PW + GW);
          exp_wr = (int'(model_val) + n) / 256;
          model_val = W'((int'(model_val) + n) % 256);
        end
        default: begin
          exp_lat = (n == 0) ? GW : n * (PW + GW);
          exp_wr = (n > int'(model_val)) ? (n - int'(model_val) - 1) / 256 + 1 : 0;
          model_val = W'((int'(model_val) - n + 256) % 256);
        end
      endcase
      run_cmd(op, arg, lat, to);
      tests_run++;
      if (to || lat != exp_lat || bus.shadow !== model_val || bus.q !== model_val) begin
        tests_failed++;
        $display("FAIL rand%0d op=%0d arg=%0d: to=%0d lat=%0d shadow=%h q=%h want lat %0d val %h",
                 i, op, arg, to, lat, bus.shadow, bus.q, exp_lat, model_val);
      end
      tests_run++;
      if (wraps - w0 != exp_wr ||
          up_rises - u0 != ((op == OP_UP) ? n : 0) ||
          down_rises - d0 != ((op == OP_DOWN) ? n : 0)) begin
        tests_failed++;
        $display("FAIL rand%0d_strobes: wraps=%0d ups=%0d downs=%0d want wraps %0d n %0d op %0d",
                 i, wraps - w0, up_rises - u0, down_rises - d0, exp_wr, n, op);
      end
    end
  endtask

  task automatic test_mismatch();
    int lat;
    bit to;
    logic exp_mm;
`ifdef LS193_SEQ_CHECK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    run_cmd(OP_LOAD, 8'h00, lat, to);
    drops_req = drops_req + 1;
    run_cmd(OP_UP, 8'd4, lat, to);
    tests_run++;
    if (to || bus.shadow !== 8'h04 || bus.q !== 8'h03 || bus.mismatch !== exp_mm) begin
      tests_failed++;
      $display("FAIL drop_pulse: to=%0d shadow=%h q=%h mismatch=%b want 04 03 %b",
               to, bus.shadow, bus.q, bus.mismatch, exp_mm);
    end
    run_cmd(OP_CLR, 8'h00, lat, to);
    tests_run++;
    if (to || bus.mismatch !== 1'b0 || bus.q !== 8'h00 || bus.shadow !== 8'h00) begin
      tests_failed++;
      $display("FAIL clr_clears_mismatch: to=%0d mismatch=%b q=%h shadow=%h want 0 00 00",
               to, bus.mismatch, bus.q, bus.shadow);
    end
    model_val = '0;
  endtask

  task automatic test_reset_mid();
    int n, u0, dn0;
    bus.cmd_op = OP_UP; bus.cmd_arg = 8'd10; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < BUDGET) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    u0 = up_rises;
    dn0 = done_cnt;
    n = 0;
    while (!(up_rises - u0 == 3 && bus.up_n == 1'b0) && n < BUDGET) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n >= BUDGET) begin
      tests_failed++;
      $display("FAIL midrst_wait: 4th pulse never seen, pulses=%0d want 3", up_rises - u0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({bus.clr, bus.load_n, bus.up_n, bus.down_n, bus.cmd_ready} !== 5'b01110) begin
      tests_failed++;
      $display("FAIL midrst_strobes: got %b want 01110", {bus.clr, bus.load_n, bus.up_n, bus.down_n, bus.cmd_ready});
    end
    n = 0;
    while (!bus.cmd_ready && n < BUDGET) begin @(posedge clk); #1; n++; end
    @(negedge clk); #1;
    tests_run++;
    if (bus.q !== 8'h00 || bus.shadow !== 8'h00 || done_cnt != dn0 || bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_recover: q=%h shadow=%h dones=%0d ready=%b want 00 00 0 1",
               bus.q, bus.shadow, done_cnt - dn0, bus.cmd_ready);
    end
    model_val = '0;
  endtask

  task automatic test_exclusive();
    tests_run++;
    if (viol != 0) begin
      tests_failed++;
      $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", viol);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_CLR;
    bus.cmd_arg = '0;
    test_reset();
    test_load_up();
    test_down_wrap();
    test_up_zero();
    test_back_to_back();
    test_random();
    test_mismatch();
    test_reset_mid();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
